// File: rtl/serial_logic_unit_if.sv
// serial_logic_unit_if: request/result bundle between the datapath and the serial logic unit
interface serial_logic_unit_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   S;
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    logic         err;
    modport master(output start, a, b, S, input busy, done, out, err);
    modport slave(input start, a, b, S, output busy, done, out, err);
endinterface

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: feeds one 1-bit logic cell LSB first and assembles its N-bit result word
// Optional CL_SELFCHECK_EN registers a parallel expected word and flags err on mismatch.
module serial_logic_unit #(
    parameter int N = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    serial_logic_unit_if.slave bus,
    output logic               cl_a,
    output logic               cl_b,
    output logic [1:0]         cl_S,
    input  logic               cl_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [N-1:0]     a_sh, b_sh, r_sh, r_next, out_r;
    logic [1:0]       s_r;
    logic [CNT_W-1:0] cnt;
    logic             busy_r, done_r, last;
    // shift form keeps N=1 legal where a part-select would not be
    assign r_next = (r_sh >> 1) | (N'(cl_out) << (N - 1));
    assign last = cnt == CNT_W'(N - 1);
    assign cl_a = busy_r & a_sh[0];
    assign cl_b = busy_r & b_sh[0];
    assign cl_S = s_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out = out_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            out_r  <= '0;
            s_r    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                s_r    <= bus.S;
                r_sh   <= '0;
                cnt    <= '0;
                busy_r <= 1'b1;
                state  <= RUN;
            end
        end else if (state == RUN) begin
            r_sh <= r_next;
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (last) begin
                out_r  <= r_next;
                done_r <= 1'b1;
                busy_r <= 1'b0;
                state  <= DONE;
            end
        end else begin
            done_r <= 1'b0;
            state  <= IDLE;
        end
    end
`ifdef CL_SELFCHECK_EN
    logic [N-1:0] e_r;
    logic         err_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r   <= '0;
            err_r <= 1'b0;
        end else begin
            if (state == IDLE && bus.start)
                e_r <= bus.S == 2'd0 ? bus.a & bus.b :
                       bus.S == 2'd1 ? bus.a | bus.b :
                       bus.S == 2'd2 ? bus.a ^ bus.b : ~bus.a;
            if (state == RUN && last)
                err_r <= r_next != e_r;
        end
    end
    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif
endmodule
